pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 89 ++++++++
 tb/tb_pwm_capture.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an incoming PWM waveform in clk cycles.
// Results are published one cycle after the closing rising edge, together with a valid pulse.
module pwm_capture #(
    parameter int XLEN        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signal,
    output logic [XLEN-1:0] ampl,
    output logic [XLEN:0]   duty_cycle,
    output logic            valid,
    output logic            err
);
    typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;
    localparam logic [XLEN:0]   PMAX = '1;
    localparam logic [XLEN-1:0] HMAX = '1;
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q, warm_q;
    logic                   s_dly_q, pub_q, valid_q, err_q;
    logic [XLEN:0]          pcnt_q, res_p_q, duty_q;
    logic [XLEN-1:0]        hcnt_q, res_h_q, ampl_q;
    logic                   s, rise;
    assign s          = sync_q[SYNC_STAGES-1];
    assign rise       = s & ~s_dly_q;
    assign ampl       = ampl_q;
    assign duty_cycle = duty_q;
    assign valid      = valid_q;
    assign err        = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            warm_q  <= '0;
            s_dly_q <= 1'b0;
            pcnt_q  <= '0;
            hcnt_q  <= '0;
            res_p_q <= '0;
            res_h_q <= '0;
            duty_q  <= '0;
            ampl_q  <= '0;
            pub_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], signal};
            warm_q  <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            s_dly_q <= s;
            pub_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= pub_q;
            if (pub_q) begin
                ampl_q <= res_h_q;
                duty_q <= res_p_q;
            end
            case (state_q)
                // s only reflects the real input once the reset zeros have left the synchronizer
                IDLE: if (warm_q[SYNC_STAGES-1] && !s) state_q <= ARMED;
                ARMED: if (rise) begin
                    pcnt_q  <= (XLEN+1)'(1);
                    hcnt_q  <= XLEN'(1);
                    state_q <= HIGH;
                end
                HIGH: if (pcnt_q == PMAX || (s && hcnt_q == HMAX)) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    pcnt_q <= pcnt_q + 1'b1;
                    if (s) hcnt_q <= hcnt_q + 1'b1;
                    else state_q <= LOW;
                end
                LOW: if (rise) begin
                    res_p_q <= pcnt_q;
                    res_h_q <= hcnt_q;
                    pub_q   <= 1'b1;
                    pcnt_q  <= (XLEN+1)'(1);
                    hcnt_q  <= XLEN'(1);
                    state_q <= HIGH;
                end else if (pcnt_q == PMAX) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    pcnt_q <= pcnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed waveforms with hand-computed period/high-time results and timing.
module tb_pwm_capture;
    logic       clk = 1'b0, rst = 1'b1, signal = 1'b0;
    logic [7:0] ampl;
    logic [8:0] duty_cycle;
    logic       valid, err;
    int cyc = 0, checks = 0, fails = 0, both = 0, k = 0;
    int v_cyc[$], v_a[$], v_p[$], e_cyc[$], rise_k[$];

    pwm_capture #(.XLEN(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .signal(signal),
        .ampl(ampl), .duty_cycle(duty_cycle), .valid(valid), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (valid) begin
            v_cyc.push_back(cyc);
            v_a.push_back(int'(ampl));
            v_p.push_back(int'(duty_cycle));
        end
        if (err) e_cyc.push_back(cyc);
        if (valid && err) both++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            signal = 1'b1;
            rise_k.push_back(cyc);
            step(h);
            signal = 1'b0;
            step(p - h);
        end
    endtask

    task automatic clear();
        v_cyc.delete(); v_a.delete(); v_p.delete(); e_cyc.delete(); rise_k.delete();
    endtask

    task automatic reset_dut();
        signal = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(4);
    endtask

    // result i closes the period opened at rise i and appears 4 edges after rise i+1 is driven
    task automatic chk_res(input string tag, input int n, input int p, input int h0, input int h1, input int sw);
        chk({tag, "_valid_count"}, v_cyc.size(), n);
        for (int i = 0; i < n && i < v_cyc.size(); i++) begin
            chk({tag, "_valid_cycle"}, v_cyc[i], rise_k[i+1] + 4);
            chk({tag, "_ampl"}, v_a[i], i < sw ? h0 : h1);
            chk({tag, "_duty"}, v_p[i], p);
        end
    endtask

    initial begin
        step(3);
        chk("rst_ampl", int'(ampl), 0);
        chk("rst_duty", int'(duty_cycle), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        step(4);
        clear();
        wave(4, 2, 6);
        step(520);
        chk_res("t1", 5, 4, 2, 2, 5);
        chk("t1_err_count", e_cyc.size(), 1);
        chk("t1_err_cycle", e_cyc.size() > 0 ? e_cyc[0] : -1, rise_k[5] + 514);
        chk("t1_hold_ampl", int'(ampl), 2);
        chk("t1_hold_duty", int'(duty_cycle), 4);
        clear();
        wave(6, 2, 4);
        step(6);
        chk_res("t2", 3, 6, 2, 2, 3);
        chk("t2_err_count", e_cyc.size(), 0);
        reset_dut();
        clear();
        wave(10, 1, 3);
        wave(10, 9, 3);
        step(6);
        chk_res("t3", 5, 10, 1, 9, 3);
        chk("t3_err_count", e_cyc.size(), 0);
        rst = 1'b1;
        signal = 1'b1;
        step(2);
        rst = 1'b0;
        clear();
        step(20);
        signal = 1'b0;
        step(5);
        wave(8, 3, 4);
        step(6);
        chk_res("t4", 3, 8, 3, 3, 3);
        chk("t4_err_count", e_cyc.size(), 0);
        reset_dut();
        clear();
        signal = 1'b1;
        k = cyc;
        step(256);
        signal = 1'b0;
        step(20);
        wave(20, 5, 3);
        step(6);
        chk("t5_err_count", e_cyc.size(), 1);
        chk("t5_err_cycle", e_cyc.size() > 0 ? e_cyc[0] : -1, k + 258);
        chk_res("t5", 2, 20, 5, 5, 2);
        reset_dut();
        clear();
        wave(6, 2, 3);
        step(6);
        chk("t6_pre_ampl", int'(ampl), 2);
        chk("t6_pre_duty", int'(duty_cycle), 6);
        signal = 1'b1;
        step(3);
        #3 rst = 1'b1;
        #1;
        chk("t6_async_ampl", int'(ampl), 0);
        chk("t6_async_duty", int'(duty_cycle), 0);
        chk("t6_async_valid", int'(valid), 0);
        chk("t6_async_err", int'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear();
        step(4);
        signal = 1'b0;
        step(4);
        wave(7, 3, 3);
        step(6);
        chk_res("t6", 2, 7, 3, 3, 2);
        chk("t6_err_count", e_cyc.size(), 0);
        chk("valid_err_overlap", both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
